serial_pattern_counter: RTL

Serial pattern matcher and per-frame match counter that sits directly downstream of the serial bit generators and detectors in the signal path. It consumes a one-bit stream qualified by a valid strobe and compares it against a runtime-programmable pattern, with overlapping matches allowed. It pulses on every match, counts matches per frame, and hands each frame's count to a consumer over a valid/ready report interface.

---
 rtl/serial_pattern_counter_if.sv | 31 +++
 rtl/serial_pattern_counter.sv | 104 ++++++++++
 2 files changed

// File: rtl/serial_pattern_counter_if.sv
// Bundles the pattern-counter data, config, match and report signals.
// Latency: none; this file only declares wires and modports.
// Backpressure: rpt_valid/rpt_ready handshake; the serial input has no backpressure.
// Ports (slave view): in  cfg_load, cfg_pattern[PAT_W], din_valid, din, frame_end, rpt_ready
//                     out match, match_cnt[CNT_W], rpt_valid, rpt_data[CNT_W], rpt_ovf
interface serial_pattern_counter_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic             din_valid;
  logic             din;
  logic             frame_end;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_data;
  logic             rpt_ovf;

  modport master (
    output cfg_load, cfg_pattern, din_valid, din, frame_end, rpt_ready,
    input  match, match_cnt, rpt_valid, rpt_data, rpt_ovf
  );

  modport slave (
    input  cfg_load, cfg_pattern, din_valid, din, frame_end, rpt_ready,
    output match, match_cnt, rpt_valid, rpt_data, rpt_ovf
  );
endinterface

// File: rtl/serial_pattern_counter.sv
// Serial pattern matcher with overlapping matches, per-frame saturating count and a frame report.
// Latency: match/match_cnt one cycle after the completing bit; report one cycle after frame_end.
// Backpressure: report held while rpt_valid & !rpt_ready; a frame_end that finds it pending sets rpt_ovf.
// Ports: clk, rst_n (async active-low); bus = serial_pattern_counter_if.slave (see interface file).
module serial_pattern_counter #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_pattern_counter_if.slave bus
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

  state_t            r_state;
  logic [PAT_W-1:0]  r_pattern;
  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_match;
  logic [CNT_W-1:0]  r_match_cnt;
  logic              r_rpt_valid;
  logic [CNT_W-1:0]  r_rpt_data;
  logic              r_rpt_ovf;

  logic              w_accept;
  logic              w_frame_end;
  logic              w_rpt_take;
  logic [PAT_W-1:0]  w_hist_nxt;
  logic              w_match;
  logic [CNT_W-1:0]  w_cnt_nxt;

  assign w_accept    = bus.din_valid && (r_state != IDLE);
  assign w_frame_end = bus.frame_end && (r_state != IDLE);
  assign w_rpt_take  = r_rpt_valid && bus.rpt_ready;
  assign w_hist_nxt  = {r_hist[PAT_W-2:0], bus.din};

  // A match needs a full window: either already in RUN, or this bit is the PAT_W-th since load.
  assign w_match = w_accept && (w_hist_nxt == r_pattern) &&
                   ((r_state == RUN) || (r_fill == FILL_LAST));

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  assign w_cnt_nxt = (w_match && (r_match_cnt != {CNT_W{1'b1}})) ?
                     r_match_cnt + CNT_W'(1) : r_match_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pattern   <= '0;
      r_hist      <= '0;
      r_fill      <= '0;
      r_match     <= 1'b0;
      r_match_cnt <= '0;
      r_rpt_valid <= 1'b0;
      r_rpt_data  <= '0;
      r_rpt_ovf   <= 1'b0;
    end else begin
      r_match <= 1'b0;
      if (bus.cfg_load) begin
        // Load wins over data and frame_end on this edge; a pending report survives,
        // but a handshake completing on this edge still retires it.
        r_state     <= FILL;
        r_pattern   <= bus.cfg_pattern;
        r_hist      <= '0;
        r_fill      <= '0;
        r_match_cnt <= '0;
        r_rpt_ovf   <= 1'b0;
        if (w_rpt_take) r_rpt_valid <= 1'b0;
      end else begin
        if (w_accept) begin
          r_hist  <= w_hist_nxt;
          r_match <= w_match;
          if (r_state == FILL) begin
            r_fill <= r_fill + FILL_W'(1);
            if (r_fill == FILL_LAST) r_state <= RUN;
          end
        end
        if (w_frame_end) begin
          r_match_cnt <= '0;
          // The slot is free if empty or being drained on this same edge.
          if (!r_rpt_valid || w_rpt_take) begin
            r_rpt_data  <= w_cnt_nxt;
            r_rpt_valid <= 1'b1;
          end else begin
            r_rpt_ovf <= 1'b1;
          end
        end else begin
          r_match_cnt <= w_cnt_nxt;
          if (w_rpt_take) r_rpt_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.match     = r_match;
  assign bus.match_cnt = r_match_cnt;
  assign bus.rpt_valid = r_rpt_valid;
  assign bus.rpt_data  = r_rpt_data;
  assign bus.rpt_ovf   = r_rpt_ovf;

endmodule
